// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the dual-clock FIFO (clk_b domain): issues read strobes,
// captures returning words into a 2-entry buffer and re-presents them as a framed valid/ready stream.
module fifo_read_ctrl #(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk_b,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_ren,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
);

  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [15:0]           r_beat_cnt;
  logic [FIFO_WIDTH-1:0] r_head;
  logic [FIFO_WIDTH-1:0] r_second;

  logic                  w_pop;
  logic [1:0]            w_occ_after_pop;
  logic [2:0]            w_level;
  logic                  w_last_beat;

  assign m_valid     = (r_occ != 2'd0);
  assign m_data      = r_head;
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);
  assign m_last      = m_valid && w_last_beat;
  assign busy        = r_inflight || m_valid;

  // A read is only issued when the word it returns next cycle is guaranteed a buffer slot.
  always_comb begin
    w_pop           = m_valid && m_ready;
    w_occ_after_pop = r_occ - {1'b0, w_pop};
    w_level         = {1'b0, w_occ_after_pop} + {2'b0, r_inflight};
    fifo_ren        = rst_n && enable && !fifo_empty && (w_level < 3'd2);
  end

  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      // NOTE: the buffer registers are reset too so m_data reads 0 out of reset, not stale data.
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_beat_cnt <= 16'd0;
      r_head     <= '0;
      r_second   <= '0;
    end else begin
      r_inflight <= fifo_ren;
      r_occ      <= w_occ_after_pop + {1'b0, r_inflight};

      if (w_pop) begin
        r_head     <= r_second;
        r_beat_cnt <= w_last_beat ? 16'd0 : r_beat_cnt + 16'd1;
      end

      // NOTE: non-blocking assignments let the capture below override the pop shift into
      // r_head in the same cycle; the last assignment in program order wins.
      if (r_inflight) begin
        if (w_occ_after_pop == 2'd0) r_head <= fifo_dout;
        else                         r_second <= fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: a table of per-cycle vectors for the basic stream,
// then directed sequences against a queue-based FIFO model and word scoreboard.
module tb_fifo_read_ctrl;

  localparam int W  = 16;
  localparam int BL = 4;

  logic         clk_b = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         fifo_empty;
  logic [W-1:0] fifo_dout;
  logic         m_ready;
  logic         fifo_ren, m_valid, m_last, busy;
  logic [W-1:0] m_data;
  logic         fifo_ren1, m_valid1, m_last1, busy1;
  logic [W-1:0] m_data1;

  fifo_read_ctrl #(.FIFO_WIDTH(W), .BURST_LEN(BL)) u_dut (
    .clk_b(clk_b), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_ren(fifo_ren), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  fifo_read_ctrl #(.FIFO_WIDTH(W), .BURST_LEN(1)) u_dut_b1 (
    .clk_b(clk_b), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_ren(fifo_ren1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready), .m_last(m_last1), .busy(busy1)
  );

  always #5 clk_b = ~clk_b;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         rst_n;
    logic         empty;
    logic [W-1:0] dout;
    logic         ren;
    logic         valid;
    logic [W-1:0] data;
    logic         last;
    logic         busy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic [W-1:0] d,
                              input logic ren, input logic v, input logic [W-1:0] dat,
                              input logic l, input logic b);
    vec_t t;
    t.rst_n = r; t.empty = e; t.dout = d;
    t.ren = ren; t.valid = v; t.data = dat; t.last = l; t.busy = b;
    return t;
  endfunction

  // FIFO model contents, expected delivery order and stream bookkeeping
  logic [W-1:0] fq[$];
  logic [W-1:0] sb[$];
  int           delivered;
  int           reads;
  int           last_cnt;
  bit           prev_stall;
  logic [W-1:0] prev_data;

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    sb.push_back(w);
  endtask

  task automatic rst_seq();
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
    fq.delete(); sb.delete();
    delivered = 0; reads = 0; last_cnt = 0; prev_stall = 1'b0; prev_data = '0;
    repeat (2) @(posedge clk_b);
    @(negedge clk_b);
    rst_n = 1'b1;
  endtask

  // One clock of the model-driven stream; called and returns at a falling edge.
  task automatic cyc(input logic en, input logic rdy, output logic o_ren, output logic o_valid);
    logic [W-1:0] exp_w;
    enable = en; m_ready = rdy; fifo_empty = (fq.size() == 0);
    #1;
    o_ren = fifo_ren; o_valid = m_valid;
    check("ren_while_empty", {31'd0, fifo_ren && fifo_empty}, 0);
    if (prev_stall) begin
      check("hold_valid", {31'd0, m_valid}, 1);
      check("hold_data", {16'd0, m_data}, {16'd0, prev_data});
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    if (m_valid) check("last_b1", {31'd0, m_last1}, 1);
    if (m_valid && m_ready) begin
      if (sb.size() > 0) exp_w = sb.pop_front();
      else               exp_w = 16'hFFFF;
      check("word", {16'd0, m_data}, {16'd0, exp_w});
      check("last", {31'd0, m_last}, {31'd0, (delivered % BL) == BL - 1});
      if (m_last) last_cnt++;
      delivered++;
    end
    if (fifo_ren) begin
      reads++;
      check("outstanding_le2", {31'd0, (reads - delivered) <= 2}, 1);
    end
    @(posedge clk_b);
    #1;
    if (o_ren && fq.size() > 0) fifo_dout = fq.pop_front();
    else                        fifo_dout = 16'hBAD0;
    fifo_empty = (fq.size() == 0);
    @(negedge clk_b);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vec_t vecs[8];
    logic r, v;
    int   rens, vals, seen;

    // Reset state
    rst_n = 1'b0; enable = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk_b);
    @(negedge clk_b);
    #1;
    check("rst_valid", {31'd0, m_valid}, 0);
    check("rst_data", {16'd0, m_data}, 0);
    check("rst_last", {31'd0, m_last}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ren", {31'd0, fifo_ren}, 0);
    @(negedge clk_b);

    // Basic stream of 0x0001..0x0004 from a preloaded FIFO, enable=1, m_ready=1
    vecs[0] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vecs[1] = mk(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0);
    vecs[2] = mk(1, 0, 16'h0001, 1, 0, 16'h0000, 0, 1);
    vecs[3] = mk(1, 0, 16'h0002, 1, 1, 16'h0001, 0, 1);
    vecs[4] = mk(1, 0, 16'h0003, 1, 1, 16'h0002, 0, 1);
    vecs[5] = mk(1, 1, 16'h0004, 0, 1, 16'h0003, 0, 1);
    vecs[6] = mk(1, 1, 16'h0000, 0, 1, 16'h0004, 1, 1);
    vecs[7] = mk(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 8; i++) begin
      rst_n = vecs[i].rst_n; enable = 1'b1; m_ready = 1'b1;
      fifo_empty = vecs[i].empty; fifo_dout = vecs[i].dout;
      #1;
      check($sformatf("v%0d_ren", i), {31'd0, fifo_ren}, {31'd0, vecs[i].ren});
      check($sformatf("v%0d_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].valid});
      check($sformatf("v%0d_last", i), {31'd0, m_last}, {31'd0, vecs[i].last});
      check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      check($sformatf("v%0d_b1_ren", i), {31'd0, fifo_ren1}, {31'd0, vecs[i].ren});
      check($sformatf("v%0d_b1_valid", i), {31'd0, m_valid1}, {31'd0, vecs[i].valid});
      check($sformatf("v%0d_b1_last", i), {31'd0, m_last1}, {31'd0, vecs[i].valid});
      check($sformatf("v%0d_b1_busy", i), {31'd0, busy1}, {31'd0, vecs[i].busy});
      if (vecs[i].valid) begin
        check($sformatf("v%0d_data", i), {16'd0, m_data}, {16'd0, vecs[i].data});
        check($sformatf("v%0d_b1_data", i), {16'd0, m_data1}, {16'd0, vecs[i].data});
      end
      @(posedge clk_b);
      @(negedge clk_b);
    end

    // Back-pressure: 10 words, m_ready low for cycles 3..8
    rst_seq();
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
    for (int c = 0; c < 60 && !(delivered == 10 && !busy); c++)
      cyc(1'b1, !(c >= 3 && c <= 8), r, v);
    check("bp_delivered", delivered, 10);
    check("bp_sb_left", sb.size(), 0);
    check("bp_busy_end", {31'd0, busy}, 0);

    // Framing with BURST_LEN=4: 9 words, random m_ready
    rst_seq();
    for (int i = 0; i < 9; i++) push(16'h0200 + 16'(i));
    for (int c = 0; c < 300 && !(delivered == 9 && !busy); c++)
      cyc(1'b1, 1'($urandom_range(0, 1)), r, v);
    check("frm_delivered", delivered, 9);
    check("frm_last_cnt", last_cnt, 2);

    // After reset the burst count restarts: word 4 of the new stream is last
    rst_seq();
    for (int i = 0; i < 4; i++) push(16'h0300 + 16'(i));
    for (int c = 0; c < 30 && !(delivered == 4 && !busy); c++) cyc(1'b1, 1'b1, r, v);
    check("frm2_delivered", delivered, 4);
    check("frm2_last_cnt", last_cnt, 1);

    // Empty boundary: a single word yields one read and one valid beat
    rst_seq();
    push(16'h0A55);
    rens = 0; vals = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, 1'b1, r, v);
      rens += int'(r); vals += int'(v);
    end
    check("eb_ren_pulses", rens, 1);
    check("eb_valid_beats", vals, 1);
    for (int c = 0; c < 5; c++) cyc(1'b1, 1'b1, r, v);
    push(16'h0B66);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      cyc(1'b1, 1'b1, r, v);
      if (r) seen = 1;
    end
    check("eb_ren_seen", seen, 1);
    cyc(1'b1, 1'b1, r, v);
    check("eb_valid_n1", {31'd0, v}, 0);
    cyc(1'b1, 1'b1, r, v);
    check("eb_valid_n2", {31'd0, v}, 1);
    check("eb_delivered", delivered, 2);

    // Enable drop while reads are streaming
    rst_seq();
    for (int i = 0; i < 6; i++) push(16'h0400 + 16'(i));
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 1'b1, r, v);
      check("ed_ren_on", {31'd0, r}, 1);
    end
    cyc(1'b0, 1'b1, r, v);
    check("ed_ren_drop", {31'd0, r}, 0);
    rens = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0, 1'b1, r, v);
      rens += int'(r);
    end
    check("ed_no_more_ren", rens, 0);
    check("ed_delivered", delivered, 3);
    check("ed_busy_end", {31'd0, busy}, 0);

    // Reset mid-stream with the buffer full and a read otherwise due
    rst_seq();
    for (int i = 0; i < 6; i++) push(16'h0500 + 16'(i));
    for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, r, v);
    check("mr_full_valid", {31'd0, m_valid}, 1);
    rst_n = 1'b0; enable = 1'b1; m_ready = 1'b1; fifo_empty = 1'b0;
    #1;
    check("mr_ren_in_rst", {31'd0, fifo_ren}, 0);
    @(posedge clk_b);
    #1;
    fq.delete(); sb.delete(); fifo_empty = 1'b1;
    @(negedge clk_b);
    #1;
    check("mr_valid", {31'd0, m_valid}, 0);
    check("mr_last", {31'd0, m_last}, 0);
    check("mr_busy", {31'd0, busy}, 0);
    check("mr_ren", {31'd0, fifo_ren}, 0);
    check("mr_data", {16'd0, m_data}, 0);
    @(negedge clk_b);
    rst_n = 1'b1;
    @(negedge clk_b);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
